// File: rtl/tone_gen_pkg.sv
// rtl/tone_gen_pkg.sv - shared state type, widths and Q11 scaling for the tone generator
package tone_gen_pkg;

    localparam int DEF_NO_BITS = 32;
    localparam int DEF_FRAC    = 11;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/q11_mul.sv
// rtl/q11_mul.sv - signed fixed-point multiply: full product, arithmetic shift by FRAC, truncate
module q11_mul
    import tone_gen_pkg::*;
#(
    parameter int no_bits = DEF_NO_BITS,
    parameter int FRAC    = DEF_FRAC
) (
    input  logic signed [no_bits-1:0] i_a,
    input  logic signed [no_bits-1:0] i_b,
    output logic signed [no_bits-1:0] o_y
);

    logic signed [2*no_bits-1:0] w_prod;
    logic signed [2*no_bits-1:0] w_shift;
    logic                        w_unused_bits;

    assign w_prod  = i_a * i_b;
    assign w_shift = w_prod >>> FRAC;
    assign o_y     = w_shift[no_bits-1:0];

    // Upper bits are dropped on purpose: the result wraps rather than saturates.
    assign w_unused_bits = ^w_shift[2*no_bits-1:no_bits];

endmodule

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - Goertzel-style recursive sine burst generator with valid/ready output
module tone_gen
    import tone_gen_pkg::*;
#(
    parameter int no_bits = DEF_NO_BITS,
    parameter int FRAC    = DEF_FRAC,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic signed [no_bits-1:0] coef,
    input  logic signed [no_bits-1:0] amp,
    input  logic        [CNT_W-1:0]   burst_len,
    output logic signed [no_bits-1:0] out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      done
);

    state_t                    r_state;
    state_t                    w_next;
    logic signed [no_bits-1:0] r_coef;
    logic signed [no_bits-1:0] r_d1;
    logic signed [no_bits-1:0] r_d2;
    logic signed [no_bits-1:0] r_prod;
    logic signed [no_bits-1:0] w_scaled;
    logic        [CNT_W-1:0]   r_len;
    logic        [CNT_W-1:0]   r_cnt;
    logic        [CNT_W-1:0]   w_cnt_inc;
    logic                      r_stop_pend;
    logic                      w_xfer;
    logic                      w_last;

    // Product is registered on the transfer so CALC only has a subtract on its path.
    q11_mul #(
        .no_bits (no_bits),
        .FRAC    (FRAC)
    ) u_mul (
        .i_a (r_coef),
        .i_b (r_d1),
        .o_y (w_scaled)
    );

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_xfer    = (r_state == ST_EMIT) && out_ready;
    assign w_last    = ((r_len != '0) && (w_cnt_inc == r_len)) || r_stop_pend || stop;
    assign out       = r_d1;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        out_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = w_last ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                w_next = ST_EMIT;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_coef      <= '0;
            r_len       <= '0;
            r_d1        <= '0;
            r_d2        <= '0;
            r_prod      <= '0;
            r_cnt       <= '0;
            r_stop_pend <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_coef      <= coef;
                        r_len       <= burst_len;
                        r_d1        <= amp;
                        r_d2        <= '0;
                        r_cnt       <= '0;
                        r_stop_pend <= 1'b0;
                    end
                end
                ST_EMIT: begin
                    if (w_xfer) begin
                        r_cnt  <= w_cnt_inc;
                        r_prod <= w_scaled;
                    end else if (stop) begin
                        r_stop_pend <= 1'b1;
                    end
                end
                ST_CALC: begin
                    r_d1 <= r_prod - r_d2;
                    r_d2 <= r_d1;
                    if (stop) begin
                        r_stop_pend <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_gen.sv
// tb/tb_tone_gen.sv - directed self-checking bench for tone_gen
module tb_tone_gen;

    logic               CLK = 1'b0;
    logic               reset;
    logic               start;
    logic               stop;
    logic signed [31:0] coef;
    logic signed [31:0] amp;
    logic        [15:0] burst_len;
    logic signed [31:0] out;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               done;

    int checks = 0;
    int errors = 0;

    logic signed [31:0] got[$];
    logic               vpat[$];
    int                 last_xfer;
    int                 done_at;
    int                 done_cnt;
    logic               stall_bad;

    tone_gen dut (
        .CLK       (CLK),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .coef      (coef),
        .amp       (amp),
        .burst_len (burst_len),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input logic signed [31:0] c, input logic signed [31:0] a,
                            input logic [15:0] n);
        coef      = c;
        amp       = a;
        burst_len = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic collect(input int budget, input int stall_idx, input int stall_len,
                           input int stop_after, input int poke_a, input int poke_b);
        int                 stall_rem;
        logic signed [31:0] held;
        logic               stop_sent;
        stall_rem = stall_len;
        held      = '0;
        stop_sent = 1'b0;
        got.delete();
        vpat.delete();
        last_xfer = -1;
        done_at   = -1;
        done_cnt  = 0;
        stall_bad = 1'b0;
        for (int c = 0; c < budget; c++) begin
            out_ready = 1'b1;
            stop      = 1'b0;
            start     = 1'b0;
            if (got.size() == stall_idx && stall_rem > 0 && (out_valid || stall_rem < stall_len)) begin
                if (stall_rem == stall_len) held = out;
                else if (!out_valid || out !== held) stall_bad = 1'b1;
                out_ready = 1'b0;
                stall_rem--;
            end
            if (!stop_sent && stop_after >= 0 && got.size() == stop_after && !out_valid && busy) begin
                stop      = 1'b1;
                stop_sent = 1'b1;
            end
            if (c == poke_a || c == poke_b) begin
                start     = 1'b1;
                coef      = 32'sd2048;
                amp       = 32'sd9999;
                burst_len = 16'd1;
            end
            vpat.push_back(out_valid);
            if (out_valid && out_ready) begin
                got.push_back(out);
                last_xfer = c;
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (done_at >= 0 && c >= done_at + 2) break;
            tick();
        end
        start     = 1'b0;
        stop      = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++;
        if ({out_valid, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 000", {out_valid, busy, done});
        end
        checks++;
        if (out !== 32'sd0) begin
            errors++;
            $display("FAIL reset_out got %0d exp 0", out);
        end
        @(negedge CLK);
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy got %b exp 0", busy);
        end
    endtask

    task automatic test_cosine();
        logic signed [31:0] e [6] = '{32'sd1000, 32'sd1000, 32'sd0, -32'sd1000, -32'sd1000, 32'sd0};
        do_start(32'sd2048, 32'sd1000, 16'd6);
        collect(60, -1, 0, -1, -1, -1);
        checks++;
        if (got.size() != 6) begin
            errors++;
            $display("FAIL cos_count got %0d exp 6", got.size());
        end
        for (int i = 0; i < 6; i++) begin
            logic signed [31:0] g;
            g = (i < got.size()) ? got[i] : 'x;
            checks++;
            if (g !== e[i]) begin
                errors++;
                $display("FAIL cos_sample[%0d] got %0d exp %0d", i, g, e[i]);
            end
        end
        checks++;
        if (done_at < 0 || done_at != last_xfer + 1 || done_cnt != 1) begin
            errors++;
            $display("FAIL cos_done at %0d cnt %0d exp at %0d cnt 1", done_at, done_cnt, last_xfer + 1);
        end
        checks++;
        if (busy !== 1'b0 || out !== 32'sd0) begin
            errors++;
            $display("FAIL cos_idle busy %b out %0d exp busy 0 out 0", busy, out);
        end
    endtask

    task automatic test_pattern();
        logic signed [31:0] e [4] = '{-32'sd500, 32'sd0, 32'sd500, 32'sd0};
        logic               v [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        do_start(32'sd0, -32'sd500, 16'd4);
        // start pokes land in CALC (cycle 1) and in DONE (cycle 7); both must be ignored
        collect(60, -1, 0, -1, 1, 7);
        for (int i = 0; i < 4; i++) begin
            logic signed [31:0] g;
            g = (i < got.size()) ? got[i] : 'x;
            checks++;
            if (g !== e[i]) begin
                errors++;
                $display("FAIL pat_sample[%0d] got %0d exp %0d", i, g, e[i]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            logic g;
            g = (i < vpat.size()) ? vpat[i] : 1'bx;
            checks++;
            if (g !== v[i]) begin
                errors++;
                $display("FAIL pat_valid[%0d] got %b exp %b", i, g, v[i]);
            end
        end
        checks++;
        if (got.size() != 4 || done_at != 7 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pat_end count %0d done_at %0d busy %b exp 4 7 0", got.size(), done_at, busy);
        end
    endtask

    task automatic test_stall();
        logic signed [31:0] e [4] = '{32'sd7, -32'sd7, 32'sd0, 32'sd7};
        do_start(-32'sd2048, 32'sd7, 16'd4);
        collect(60, 1, 5, -1, -1, -1);
        for (int i = 0; i < 4; i++) begin
            logic signed [31:0] g;
            g = (i < got.size()) ? got[i] : 'x;
            checks++;
            if (g !== e[i]) begin
                errors++;
                $display("FAIL stall_sample[%0d] got %0d exp %0d", i, g, e[i]);
            end
        end
        checks++;
        if (stall_bad !== 1'b0) begin
            errors++;
            $display("FAIL stall_stable got unstable=%b exp 0", stall_bad);
        end
        checks++;
        if (got.size() != 4 || done_cnt != 1 || out !== 32'sd7) begin
            errors++;
            $display("FAIL stall_end count %0d done %0d out %0d exp 4 1 7", got.size(), done_cnt, out);
        end
    endtask

    task automatic test_stop();
        logic signed [31:0] e [4] = '{32'sd100, 32'sd100, 32'sd0, -32'sd100};
        do_start(32'sd2048, 32'sd100, 16'd0);
        collect(60, -1, 0, 3, -1, -1);
        checks++;
        if (got.size() != 4 || done_cnt != 1 || done_at != last_xfer + 1) begin
            errors++;
            $display("FAIL stop_count got %0d done %0d at %0d exp 4 1 %0d", got.size(), done_cnt, done_at, last_xfer + 1);
        end
        for (int i = 0; i < 4; i++) begin
            logic signed [31:0] g;
            g = (i < got.size()) ? got[i] : 'x;
            checks++;
            if (g !== e[i]) begin
                errors++;
                $display("FAIL stop_sample[%0d] got %0d exp %0d", i, g, e[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        out_ready = 1'b1;
        do_start(32'sd0, -32'sd500, 16'd6);
        for (int i = 0; i < 4; i++) begin
            if (done) dones++;
            tick();
        end
        checks++;
        if (out_valid !== 1'b1 || out !== 32'sd500) begin
            errors++;
            $display("FAIL mid_pre valid %b out %0d exp 1 500", out_valid, out);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out !== 32'sd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_async valid %b out %0d busy %b exp 0 0 0", out_valid, out, busy);
        end
        for (int i = 0; i < 2; i++) begin
            if (done) dones++;
            tick();
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (done || busy) dones++;
            tick();
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL mid_nodone got %0d exp 0", dones);
        end
        do_start(32'sd2048, 32'sd1000, 16'd6);
        collect(60, -1, 0, -1, -1, -1);
        checks++;
        if (got.size() != 6 || got[0] !== 32'sd1000 || got[3] !== -32'sd1000) begin
            errors++;
            $display("FAIL mid_restart count %0d exp 6 first/fourth 1000/-1000", got.size());
        end
    endtask

    function automatic logic signed [31:0] mdl_scale(input longint c, input longint y);
        longint p;
        p = (c * y) >>> 11;
        return p[31:0];
    endfunction

    task automatic test_wrap();
        logic signed [31:0] e [5];
        logic signed [31:0] p1;
        logic signed [31:0] p2;
        p2 = 32'sd0;
        p1 = 32'sh40000000;
        e[0] = p1;
        for (int i = 1; i < 5; i++) begin
            e[i] = mdl_scale(64'sd4095, longint'(p1)) - p2;
            p2 = p1;
            p1 = e[i];
        end
        do_start(32'sd4095, 32'sh40000000, 16'd5);
        collect(60, -1, 0, -1, -1, -1);
        for (int i = 0; i < 5; i++) begin
            logic signed [31:0] g;
            g = (i < got.size()) ? got[i] : 'x;
            checks++;
            if (g !== e[i]) begin
                errors++;
                $display("FAIL wrap_sample[%0d] got %0d exp %0d", i, g, e[i]);
            end
        end
        checks++;
        if (got.size() < 3 || got[2] !== -32'sd1075838720) begin
            errors++;
            $display("FAIL wrap_hand got %0d exp -1075838720", (got.size() < 3) ? 0 : got[2]);
        end
    endtask

    initial begin
        start     = 1'b0;
        stop      = 1'b0;
        coef      = '0;
        amp       = '0;
        burst_len = '0;
        out_ready = 1'b1;
        test_reset();
        test_cosine();
        test_pattern();
        test_stall();
        test_stop();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tone_gen.md
TONE_GEN -- requirements
Module: tone_gen

Interface
REQ-001 Parameter no_bits, default 32: sample/coefficient width, two's complement.
REQ-002 Parameter FRAC, default 11: coefficient fraction bits (Q11).
REQ-003 Parameter CNT_W, default 16: burst counter width.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  begin a tone burst; sampled in IDLE only.
REQ-007 stop  input  1  request early end of a continuous or running burst.
REQ-008 coef  input  signed no_bits  2cos(w) in Q11 (2048 = 1.0); latched on start.
REQ-009 amp  input  signed no_bits  seed sample (first output); latched on start.
REQ-010 burst_len  input  CNT_W  samples per burst; 0 = continuous; latched on start.
REQ-011 out  output  signed no_bits  current sample.
REQ-012 out_valid  output  1  out holds a sample offered to the downstream filter.
REQ-013 out_ready  input  1  downstream accepts; transfer = out_valid & out_ready on a rising edge.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse on burst completion.

Function
REQ-016 FSM states IDLE, EMIT, CALC, DONE; encoding is implementation-defined.
REQ-017 IDLE: start=1 -> latch coef/amp/burst_len, d1<=amp, d2<=0, cnt<=0, clear stop_pending, go EMIT; out_valid rises the cycle after start.
REQ-018 EMIT: out_valid=1, out=d1; out and out_valid stay stable until a transfer.
REQ-019 EMIT transfer: cnt<=cnt+1, prod<=coef*d1 (full 2*no_bits signed); go DONE if (burst_len!=0 and cnt+1==burst_len) or stop_pending or stop; else go CALC.
REQ-020 CALC: out_valid=0; d1<=(prod>>>FRAC) truncated to no_bits minus d2, two's-complement wrap, no saturation; d2<=d1; go EMIT.
REQ-021 Throughput: at most one sample per 2 cycles; with out_ready held 1, out_valid toggles 1,0,1,0.
REQ-022 Recurrence: y0=amp, y1=(coef*amp)>>>11, yn=((coef*y(n-1))>>>11)-y(n-2); bit-exact.
REQ-023 stop in EMIT without transfer, or in CALC: set stop_pending; the pending or next sample is still transferred, then DONE; out_valid never retracts without a transfer.
REQ-024 DONE: done=1 for exactly one cycle, out_valid=0, go IDLE; start in DONE is ignored.
REQ-025 start while busy is ignored; latched coef/amp/burst_len unaffected.
REQ-026 burst_len=0 runs until stop; cnt wraps silently at 2^CNT_W.
REQ-027 out holds the last transferred sample while in IDLE/DONE.

Reset
REQ-028 reset low immediately forces state IDLE, out=0, out_valid=0, busy=0, done=0, d1=d2=prod=cnt=0, stop_pending=0, latched inputs=0.
REQ-029 reset mid-burst abandons the burst with no done pulse; the first start after release begins a fresh burst.

Structure
REQ-030 Package tone_gen_pkg holds FSM state type, FRAC, default widths.
REQ-031 One sub-module q11_mul: signed multiply, arithmetic shift by FRAC, truncate to no_bits; shared with the filter chain.

Verification
REQ-032 coef=2048, amp=1000, burst_len=6, out_ready=1 -> out 1000,1000,0,-1000,-1000,0; done one cycle after 6th transfer; busy low after.
REQ-033 coef=0, amp=-500, burst_len=4 -> -500,0,500,0; valid pattern 1,0,1,0,1,0,1.
REQ-034 coef=-2048, amp=7, burst_len=4, out_ready low 5 cycles at 2nd sample -> 7,-7,0,7; out/out_valid stable during stall.
REQ-035 burst_len=0, coef=2048, stop pulse in CALC after 3rd transfer -> exactly 4 samples, then done.
REQ-036 reset low during EMIT of sample 3 -> out_valid=0, out=0 asynchronously, no done; new start -> sequence restarts at amp.
REQ-037 coef=4095, amp=0x40000000, burst_len=5 -> out matches bit-exact model including wrap.
